fepow: RTL and testbench
========================

// Module: fepow
// PURPOSE
//  Requester side of the femul start/done handshake: drives one external femul to compute
//  out = a^EXP mod p, p = 2^255-19, by MSB-first square-and-multiply. Default EXP = p-2,
//  which makes this the field inverter used by the curve25519 ladder's final affine conversion.
//  Owns only the sequencing; all modular arithmetic is done in femul.
// PARAMETERS
//  EXP   255'h7fff..ffeb (p-2)   exponent, compile-time constant; any value 0..2^255-1
// PORTS
//  clock      in   1    single clock, all logic on posedge
//  reset_n    in   1    asynchronous, active-low reset
//  start      in   1    one-cycle request; sampled only in IDLE
//  a          in   255  base; captured on the accepted start
//  done       out  1    one-cycle pulse; out is valid from this cycle
//  out        out  255  result; held until the next accepted start
//  busy       out  1    high from the cycle after an accepted start through the done cycle
//  mul_start  out  1    to femul start; registered one-cycle pulse
//  mul_a      out  255  to femul operand a; registered
//  mul_b      out  255  to femul operand b; registered
//  mul_done   in   1    from femul done
//  mul_out    in   255  from femul out
// BEHAVIOUR
//  Reset (async): state=IDLE; done, busy, mul_start = 0; out, mul_a, mul_b = 0.
//  Reset mid-run abandons the run; femul's in-flight result is discarded. femul restarts on
//  start, and its done refers to the latest start.
//  States: IDLE -> SQR -> SQW -> (MUL -> MLW) -> ... -> FIN -> IDLE.
//   IDLE: on start, acc<=a, base<=a, idx<=msb(EXP)-1.
//     EXP==0 -> FIN with acc=1; EXP==1 -> FIN with acc=a; else -> SQR.
//   SQR: mul_start=1, mul_a=mul_b=acc -> SQW.
//   SQW: wait for mul_done; acc<=mul_out; if EXP[idx] -> MUL, else step.
//   MUL: mul_start=1, mul_a=acc, mul_b=base -> MLW.
//   MLW: wait for mul_done; acc<=mul_out; step.
//   Step: idx==0 -> FIN, else idx<=idx-1 -> SQR.
//   FIN: out<=acc, done=1 for one cycle -> IDLE.
//  Handshake rules:
//   - mul_a and mul_b are stable from the mul_start cycle until mul_done is sampled.
//   - mul_done is ignored in the mul_start cycle and in every state other than SQW/MLW.
//   - Next mul_start comes at the earliest one cycle after mul_done is sampled.
//  Ops per run = (msb(EXP)) squarings + (popcount(EXP)-1) multiplies; 506 for p-2.
//  Latency = sum of femul latencies + 2 cycles per op + 2 cycles (start->SQR, FIN).
//  start while busy is ignored; start in the FIN cycle is ignored.
//  a is not required to be canonical (femul reduces it). a=0 gives 0 for EXP>0.
// CONFIGURATION
//  FEPOW_OPCOUNT_EN defined: adds output op_count[9:0].
//   - Cleared on accepted start, +1 per mul_start, holds its final value after done.
//   - Saturates at 1023. Reset value 0.
//  FEPOW_OPCOUNT_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package fe_pkg holds:
//   - FE_W=255 and P=255'h7fff..ffed;
//   - P_MINUS_2;
//   - function msb_index(input [254:0]) returning [7:0];
//   - state enum fepow_state_t.
//  No sub-module inside fepow. Natural companion wrapper fepow_unit = fepow + femul wired
//  mul_*<->femul; benches test through fepow_unit.
// TESTING
//  1. a=1, EXP=p-2 -> out=1; done pulses once; op_count=506 (with FEPOW_OPCOUNT_EN).
//  2. a=2 -> out=0x3fff..fff7 (2^254-9); check 2*out mod p == 1.
//  3. a=p-1 (0x7fff..ffec) -> out=0x7fff..ffec; a=0 -> out=0.
//  4. start re-pulsed mid-run with a=5 -> ignored; result still inverse of original a;
//     busy high throughout.
//  5. reset_n low mid-run (in SQW) -> outputs 0 next edge; new start a=2 -> correct inverse.
//  6. EXP=1 -> out=a, zero mul_start; EXP=0 -> out=1; EXP=3, a=3 -> out=27.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared field constants, state encoding and helpers for the p = 2^255-19 datapath blocks.
package fe_pkg;

  localparam int FE_W = 255;
  localparam logic [FE_W-1:0] P         = ~255'd18;
  localparam logic [FE_W-1:0] P_MINUS_2 = ~255'd20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    SQW  = 3'd2,
    MUL  = 3'd3,
    MLW  = 3'd4,
    FIN  = 3'd5
  } fepow_state_t;

  // Position of the highest set bit; 0 when the value is 0 or 1.
  function automatic logic [7:0] msb_index(input logic [254:0] v);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 255; i++) begin
      if (v[i]) r = i[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fepow.sv
// Exponentiation sequencer out = a^EXP mod p driving an external femul via start/done.
// Optional op counter output enabled by defining FEPOW_OPCOUNT_EN.
module fepow
  import fe_pkg::*;
#(
  parameter logic [FE_W-1:0] EXP = P_MINUS_2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [FE_W-1:0] a,
  output logic            done,
  output logic [FE_W-1:0] out,
  output logic            busy,
  output logic            mul_start,
  output logic [FE_W-1:0] mul_a,
  output logic [FE_W-1:0] mul_b,
`ifdef FEPOW_OPCOUNT_EN
  output logic [9:0]      op_count,
`endif
  input  logic            mul_done,
  input  logic [FE_W-1:0] mul_out
);

  localparam logic [7:0] TOP = msb_index(EXP);

  fepow_state_t    state;
  logic [FE_W-1:0] acc;
  logic [FE_W-1:0] base;
  logic [7:0]      idx;

  // Square-and-multiply sequencer; out/done are loaded on the transition into FIN
  // so the result is visible in the same cycle as the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      base      <= '0;
      idx       <= 8'd0;
      done      <= 1'b0;
      out       <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
`ifdef FEPOW_OPCOUNT_EN
      op_count  <= 10'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            acc  <= a;
            base <= a;
            idx  <= TOP - 8'd1;
`ifdef FEPOW_OPCOUNT_EN
            op_count <= 10'd0;
`endif
            if (EXP == 255'd0) begin
              acc   <= 255'd1;
              out   <= 255'd1;
              done  <= 1'b1;
              state <= FIN;
            end else if (EXP == 255'd1) begin
              out   <= a;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= SQR;
            end
          end
        end
        SQR, MUL: begin
          mul_start <= 1'b1;
          mul_a     <= acc;
          mul_b     <= (state == MUL) ? base : acc;
          state     <= (state == MUL) ? MLW : SQW;
`ifdef FEPOW_OPCOUNT_EN
          if (op_count != 10'd1023) op_count <= op_count + 10'd1;
`endif
        end
        SQW, MLW: begin
          // The start cycle itself never carries a valid done for this request.
          if (mul_start) begin
            mul_start <= 1'b0;
          end else if (mul_done) begin
            acc <= mul_out;
            if (state == SQW && EXP[idx]) begin
              state <= MUL;
            end else if (idx == 8'd0) begin
              out   <= mul_out;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx   <= idx - 8'd1;
              state <= SQR;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          mul_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fepow.sv
// Bench for fepow: four instances (EXP = p-2, 1, 0, 3), each paired with a behavioural femul.
module tb_fepow;

  localparam logic [254:0] PP   = ~255'd18;
  localparam logic [254:0] PM1  = ~255'd19;
  localparam int           MLAT = 3;

  logic         clock;
  logic         reset_n;
  logic         start_v     [4];
  logic [254:0] a_v         [4];
  logic         done_v      [4];
  logic [254:0] out_v       [4];
  logic         busy_v      [4];
  logic         mul_start_v [4];
  logic [254:0] mul_a_v     [4];
  logic         hs_bad_v    [4];
`ifdef FEPOW_OPCOUNT_EN
  logic [9:0]   opc_v       [4];
`endif

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [254:0] exp_of(input int g);
    case (g)
      0:       return ~255'd20;
      1:       return 255'd1;
      2:       return 255'd0;
      3:       return 255'd3;
      default: return 255'd0;
    endcase
  endfunction

  // Reference modular product by double-and-add.
  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [255:0] r, xa, pp;
    pp = {1'b0, PP};
    xa = {1'b0, x};
    if (xa >= pp) xa = xa - pp;
    r = 256'd0;
    for (int i = 254; i >= 0; i--) begin
      r = r << 1;
      if (r >= pp) r = r - pp;
      if (y[i]) begin
        r = r + xa;
        if (r >= pp) r = r - pp;
      end
    end
    return r[254:0];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_u
    logic         mst, mdone, hsbad;
    logic [254:0] ma, mb, mout, pa, pb;
    int           cnt;

    fepow #(.EXP(exp_of(g))) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start_v[g]),
      .a         (a_v[g]),
      .done      (done_v[g]),
      .out       (out_v[g]),
      .busy      (busy_v[g]),
      .mul_start (mst),
      .mul_a     (ma),
      .mul_b     (mb),
`ifdef FEPOW_OPCOUNT_EN
      .op_count  (opc_v[g]),
`endif
      .mul_done  (mdone),
      .mul_out   (mout)
    );

    assign mul_start_v[g] = mst;
    assign mul_a_v[g]     = ma;
    assign hs_bad_v[g]    = hsbad;

    // Behavioural femul with fixed latency; flags operands changing mid-operation.
    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= 0;
        mdone <= 1'b0;
        mout  <= '0;
        pa    <= '0;
        pb    <= '0;
        hsbad <= 1'b0;
      end else begin
        mdone <= 1'b0;
        if (mst) begin
          pa  <= ma;
          pb  <= mb;
          cnt <= MLAT;
        end else if (cnt != 0) begin
          if (ma !== pa || mb !== pb) hsbad <= 1'b1;
          cnt <= cnt - 1;
          if (cnt == 1) begin
            mdone <= 1'b1;
            mout  <= mulmod(pa, pb);
          end
        end
      end
    end
  end

  // One run on instance g; optionally re-pulses start (a=5) at cycle pulse_at.
  task automatic do_run(input int g, input logic [254:0] av, input int pulse_at,
                        output logic [254:0] res, output int nmul, output int busy_low);
    int cyc;
    @(negedge clock);
    start_v[g] = 1'b1;
    a_v[g]     = av;
    @(negedge clock);
    start_v[g] = 1'b0;
    cyc = 0; nmul = 0; busy_low = 0; res = '0;
    while (!done_v[g] && cyc < 20000) begin
      if (!busy_v[g]) busy_low++;
      if (mul_start_v[g]) nmul++;
      if (cyc == pulse_at) begin
        start_v[g] = 1'b1;
        a_v[g]     = 255'd5;
      end else begin
        start_v[g] = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start_v[g] = 1'b0;
    checks++;
    if (!done_v[g]) begin
      errors++;
      $display("FAIL run_timeout inst=%0d: done=%b required 1", g, done_v[g]);
    end
    if (!busy_v[g]) busy_low++;
    res = out_v[g];
  endtask

  task automatic test_reset();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (done_v[g] !== 1'b0 || busy_v[g] !== 1'b0 || mul_start_v[g] !== 1'b0 ||
          out_v[g] !== 255'd0 || mul_a_v[g] !== 255'd0) begin
        errors++;
        $display("FAIL reset inst=%0d: done=%b busy=%b mul_start=%b out=%h mul_a=%h required all 0",
                 g, done_v[g], busy_v[g], mul_start_v[g], out_v[g], mul_a_v[g]);
      end
    end
  endtask

  task automatic test_inv_one();
    logic [254:0] r; int nm, bl;
    do_run(0, 255'd1, -1, r, nm, bl);
    checks++;
    if (r !== 255'd1) begin errors++; $display("FAIL inv_one: out=%h required 1", r); end
    checks++;
    if (nm !== 506) begin errors++; $display("FAIL inv_one_ops: mul_start=%0d required 506", nm); end
`ifdef FEPOW_OPCOUNT_EN
    checks++;
    if (opc_v[0] !== 10'd506) begin errors++; $display("FAIL op_count: %0d required 506", opc_v[0]); end
`endif
    @(negedge clock);
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_once: done=%b busy=%b required 0 0", done_v[0], busy_v[0]);
    end
  endtask

  task automatic test_inv_two();
    logic [254:0] r; int nm, bl;
    do_run(0, 255'd2, -1, r, nm, bl);
    checks++;
    if (r !== ((255'd1 << 254) - 255'd9)) begin errors++; $display("FAIL inv_two: out=%h required 2^254-9", r); end
    checks++;
    if (mulmod(255'd2, r) !== 255'd1) begin errors++; $display("FAIL inv_two_prod: 2*out=%h required 1", mulmod(255'd2, r)); end
  endtask

  task automatic test_edges();
    logic [254:0] r; int nm, bl;
    do_run(0, PM1, -1, r, nm, bl);
    checks++;
    if (r !== PM1) begin errors++; $display("FAIL inv_pm1: out=%h required %h", r, PM1); end
    do_run(0, 255'd0, -1, r, nm, bl);
    checks++;
    if (r !== 255'd0) begin errors++; $display("FAIL inv_zero: out=%h required 0", r); end
  endtask

  task automatic test_restart_ignored();
    logic [254:0] r; int nm, bl;
    do_run(0, 255'd4, 50, r, nm, bl);
    checks++;
    if (r !== ((255'd3 << 253) - 255'd14)) begin errors++; $display("FAIL restart_ignored: out=%h required 3*2^253-14", r); end
    checks++;
    if (bl !== 0) begin errors++; $display("FAIL busy_throughout: low cycles=%0d required 0", bl); end
  endtask

  task automatic test_reset_mid_run();
    logic [254:0] r; int nm, bl, n;
    @(negedge clock);
    start_v[0] = 1'b1;
    a_v[0]     = 255'd7;
    @(negedge clock);
    start_v[0] = 1'b0;
    n = 0;
    while (!mul_start_v[0] && n < 100) begin @(negedge clock); n++; end
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (out_v[0] !== 255'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 ||
        mul_start_v[0] !== 1'b0 || mul_a_v[0] !== 255'd0) begin
      errors++;
      $display("FAIL reset_mid_run: out=%h busy=%b done=%b mul_start=%b mul_a=%h required all 0",
               out_v[0], busy_v[0], done_v[0], mul_start_v[0], mul_a_v[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    do_run(0, 255'd2, -1, r, nm, bl);
    checks++;
    if (r !== ((255'd1 << 254) - 255'd9)) begin errors++; $display("FAIL after_reset_inv: out=%h required 2^254-9", r); end
  endtask

  task automatic test_small_exp();
    logic [254:0] r; int nm, bl;
    do_run(1, 255'h1234_5678, -1, r, nm, bl);
    checks++;
    if (r !== 255'h1234_5678) begin errors++; $display("FAIL exp1: out=%h required 12345678", r); end
    checks++;
    if (nm !== 0) begin errors++; $display("FAIL exp1_ops: mul_start=%0d required 0", nm); end
    do_run(2, 255'd9, -1, r, nm, bl);
    checks++;
    if (r !== 255'd1) begin errors++; $display("FAIL exp0: out=%h required 1", r); end
    do_run(3, 255'd3, -1, r, nm, bl);
    checks++;
    if (r !== 255'd27) begin errors++; $display("FAIL exp3: out=%0d required 27", r); end
    checks++;
    if (nm !== 2) begin errors++; $display("FAIL exp3_ops: mul_start=%0d required 2", nm); end
`ifdef FEPOW_OPCOUNT_EN
    checks++;
    if (opc_v[3] !== 10'd2) begin errors++; $display("FAIL exp3_op_count: %0d required 2", opc_v[3]); end
`endif
  endtask

  task automatic test_handshake();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (hs_bad_v[g] !== 1'b0) begin
        errors++;
        $display("FAIL operand_stable inst=%0d: changed=%b required 0", g, hs_bad_v[g]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start_v[g] = 1'b0;
      a_v[g]     = '0;
    end
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    test_inv_one();
    test_inv_two();
    test_edges();
    test_restart_ignored();
    test_reset_mid_run();
    test_small_exp();
    test_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
